// File: rtl/melody_pkg.sv
// Shared definitions for the melody player: sequencer state encoding, the rest
// code and default timing constants used by the sequencer, tone generator and bench.
package melody_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_D,
        PLAY,
        GAP
    } state_t;

    localparam int NOTE_REST          = 0;
    localparam int DEF_MELODY_LEN     = 7;
    localparam int DEF_NOTE_TICKS     = 12500000;
    localparam int DEF_GAP_TICKS      = 1250000;

    // Bits needed to hold the larger of the two tick counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter shared by the note and gap phases; zero is high once
// the loaded count has fully drained.
module note_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody ROM, holding each note then a silent gap.
// Optional MELODY_TEMPO_SCALE_EN adds tempo_sel to shorten notes per playback.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int MELODY_LEN = DEF_MELODY_LEN,
    parameter int ADDR_W     = 3,
    parameter int NOTE_W     = 2,
    parameter int NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
`ifdef MELODY_TEMPO_SCALE_EN
    input  logic [1:0]        tempo_sel,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_q,
    output logic [NOTE_W-1:0] note_code,
    output logic              note_valid,
    output logic              busy,
    output logic              done,
    output state_t            fsm_state
);

    localparam int CNT_W    = cnt_width(NOTE_TICKS, GAP_TICKS);
    localparam int GAP_LOAD = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    state_t           state;
    logic             zero;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] note_load;
    logic             advance;
    logic             last_entry;

`ifdef MELODY_TEMPO_SCALE_EN
    logic [1:0]  tempo_q;
    logic [31:0] scaled;

    // Never let a scaled note collapse below one cycle.
    always_comb begin
        scaled    = 32'(NOTE_TICKS) >> tempo_q;
        note_load = (scaled > 32'd1) ? CNT_W'(scaled - 32'd1) : '0;
    end
`else
    assign note_load = CNT_W'(NOTE_TICKS - 1);
`endif

    assign load       = (state == FETCH_D) || ((state == PLAY) && zero && (GAP_TICKS > 0));
    assign load_value = (state == FETCH_D) ? note_load : CNT_W'(GAP_LOAD);
    assign advance    = zero && (((state == PLAY) && (GAP_TICKS == 0)) || (state == GAP));
    assign last_entry = (rom_addr >= ADDR_W'(MELODY_LEN - 1));
    assign fsm_state  = state;

    note_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .zero       (zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rom_addr   <= '0;
            note_code  <= '0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MELODY_TEMPO_SCALE_EN
            tempo_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Abort leaves note_code untouched so the last note stays visible.
            if (stop && (state != IDLE)) begin
                state      <= IDLE;
                note_valid <= 1'b0;
                busy       <= 1'b0;
                rom_addr   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= FETCH_A;
`ifdef MELODY_TEMPO_SCALE_EN
                            tempo_q  <= tempo_sel;
`endif
                        end
                    end
                    FETCH_A: state <= FETCH_D;
                    FETCH_D: begin
                        note_code  <= rom_q;
                        note_valid <= (rom_q != NOTE_W'(NOTE_REST));
                        state      <= PLAY;
                    end
                    PLAY, GAP: begin
                        if ((state == PLAY) && zero) begin
                            note_valid <= 1'b0;
                            if (GAP_TICKS > 0) state <= GAP;
                        end
                        if (advance) begin
                            if (!last_entry) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= FETCH_A;
                            end else if (loop_en) begin
                                rom_addr <= '0;
                                state    <= FETCH_A;
                            end else begin
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                rom_addr <= '0;
                                state    <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a registered ROM model feeds two instances (normal
// gap and zero gap); outputs are checked every cycle against a timing model.
module tb_melody_sequencer;
    import melody_pkg::*;

    typedef struct packed {
        logic [2:0] addr;
        logic [1:0] code;
        logic       valid;
        logic       busy;
        logic       done;
    } exp_t;

`ifdef MELODY_TEMPO_SCALE_EN
    localparam int N2_PARAM = 4;
`else
    localparam int N2_PARAM = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start1, start2, stop, loop_en;
    logic [1:0] tempo_sel1, tempo_sel2;
    logic [2:0] rom_addr1, rom_addr2;
    logic [1:0] rom_q1, rom_q2;
    logic [1:0] note_code1, note_code2;
    logic       note_valid1, note_valid2, busy1, busy2, done1, done2;
    state_t     fsm_state1, fsm_state2;

    logic [1:0] rom_mem [7];
    logic [7:0] exp_q [$];
    int         checks   = 0;
    int         failures = 0;
    int         cur_k    = 0;
    logic [1:0] prev1, prev2;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_q1 <= rom_mem[rom_addr1];
        rom_q2 <= rom_mem[rom_addr2];
    end

    melody_sequencer #(
        .MELODY_LEN(7), .ADDR_W(3), .NOTE_W(2), .NOTE_TICKS(4), .GAP_TICKS(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop), .loop_en(loop_en),
`ifdef MELODY_TEMPO_SCALE_EN
        .tempo_sel(tempo_sel1),
`endif
        .rom_addr(rom_addr1), .rom_q(rom_q1), .note_code(note_code1),
        .note_valid(note_valid1), .busy(busy1), .done(done1), .fsm_state(fsm_state1)
    );

    melody_sequencer #(
        .MELODY_LEN(7), .ADDR_W(3), .NOTE_W(2), .NOTE_TICKS(N2_PARAM), .GAP_TICKS(0)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .stop(1'b0), .loop_en(1'b0),
`ifdef MELODY_TEMPO_SCALE_EN
        .tempo_sel(tempo_sel2),
`endif
        .rom_addr(rom_addr2), .rom_q(rom_q2), .note_code(note_code2),
        .note_valid(note_valid2), .busy(busy2), .done(done2), .fsm_state(fsm_state2)
    );

    // ---------------- reference model ----------------
    // Outputs k cycles after start is accepted: each entry takes 2 fetch cycles,
    // n sounding cycles and g silent cycles; 'laps' passes through the ROM are played.
    function automatic exp_t model(input int k, input int n, input int g,
                                   input int laps, input logic [1:0] prev);
        exp_t e;
        int   per, p, r, ent;
        per = 2 + n + g;
        p   = k / per;
        r   = k % per;
        if (p >= laps * 7) begin
            e.addr  = 3'd0;
            e.code  = rom_mem[6];
            e.valid = 1'b0;
            e.busy  = 1'b0;
            e.done  = (k == laps * 7 * per);
        end else begin
            ent     = p % 7;
            e.addr  = 3'(ent);
            e.busy  = 1'b1;
            e.done  = 1'b0;
            e.valid = (r >= 2) && (r < 2 + n) && (rom_mem[ent] != 2'd0);
            if (r >= 2)      e.code = rom_mem[ent];
            else if (p == 0) e.code = prev;
            else             e.code = rom_mem[(p + 6) % 7];
        end
        return e;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d: observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic check_outputs(input int which, input exp_t e);
        logic [2:0] a;
        logic [1:0] c;
        logic       v, b, d;
        if (which == 1) begin
            a = rom_addr1; c = note_code1; v = note_valid1; b = busy1; d = done1;
        end else begin
            a = rom_addr2; c = note_code2; v = note_valid2; b = busy2; d = done2;
        end
        cmp($sformatf("dut%0d.rom_addr", which),   32'(a), 32'(e.addr));
        cmp($sformatf("dut%0d.note_code", which),  32'(c), 32'(e.code));
        cmp($sformatf("dut%0d.note_valid", which), 32'(v), 32'(e.valid));
        cmp($sformatf("dut%0d.busy", which),       32'(b), 32'(e.busy));
        cmp($sformatf("dut%0d.done", which),       32'(d), 32'(e.done));
    endtask

    // Start a playback and check every cycle up to offset 'upto'; random extra
    // start pulses land while busy and must be ignored.
    task automatic play(input int which, input int n, input int g, input int laps,
                        input int upto, input int drop_k, input logic [1:0] prev);
        int fin;
        fin = laps * 7 * (2 + n + g);
        exp_q.delete();
        for (int k = 0; k <= upto; k++) exp_q.push_back(model(k, n, g, laps, prev));
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        tick();
        start1 = 1'b0; start2 = 1'b0;
        cur_k = 0;
        check_outputs(which, exp_q.pop_front());
        for (int k = 1; k <= upto; k++) begin
            if ((k - 1 < fin) && ($urandom_range(0, 7) == 0)) begin
                if (which == 1) start1 = 1'b1; else start2 = 1'b1;
            end
`ifdef MELODY_TEMPO_SCALE_EN
            if (which == 2) tempo_sel2 = 2'($urandom_range(0, 3));
`endif
            tick();
            start1 = 1'b0; start2 = 1'b0;
            cur_k = k;
            check_outputs(which, exp_q.pop_front());
            if (k == drop_k) loop_en = 1'b0;
        end
`ifdef MELODY_TEMPO_SCALE_EN
        tempo_sel2 = 2'd2;
`endif
    endtask

    task automatic load_default_rom();
        rom_mem[0] = 2'd3; rom_mem[1] = 2'd2; rom_mem[2] = 2'd1; rom_mem[3] = 2'd2;
        rom_mem[4] = 2'd3; rom_mem[5] = 2'd3; rom_mem[6] = 2'd3;
    endtask

    // ---------------- directed steps ----------------
    initial begin
        exp_t idle_e;
        int   r;
        reset_n = 1'b0; start1 = 1'b0; start2 = 1'b0; stop = 1'b0; loop_en = 1'b0;
        tempo_sel1 = 2'd0; tempo_sel2 = 2'd2;
        load_default_rom();
        prev1 = 2'd0; prev2 = 2'd0;
        idle_e = '0;

        // Reset values
        tick(); tick();
        cur_k = -1;
        check_outputs(1, idle_e);
        check_outputs(2, idle_e);
        cmp("dut1.fsm_state_reset", 32'(fsm_state1), 32'(IDLE));
        reset_n = 1'b1;
        tick();

        // Basic playback, done 56 cycles after start, then idle
        play(1, 4, 2, 1, 59, -1, prev1);
        prev1 = rom_mem[6];

        // start together with stop in IDLE is refused
        start1 = 1'b1; stop = 1'b1;
        tick();
        start1 = 1'b0; stop = 1'b0;
        cur_k = -2;
        cmp("start_stop_idle.busy", 32'(busy1), 32'd0);
        cmp("start_stop_idle.state", 32'(fsm_state1), 32'(IDLE));
        tick();
        cmp("start_stop_idle.busy_after", 32'(busy1), 32'd0);

        // Looping with random ROM (at least one rest), loop_en dropped in entry 6's gap
        for (int i = 0; i < 7; i++) rom_mem[i] = 2'($urandom_range(0, 3));
        rom_mem[$urandom_range(0, 6)] = 2'd0;
        loop_en = 1'b1;
        play(1, 4, 2, 2, 14 * 8 + 3, 14 * 8 - 2 + int'($urandom_range(0, 1)), prev1);
        loop_en = 1'b0;
        prev1 = rom_mem[6];

        // stop during entry 2's note
        load_default_rom();
        r = int'($urandom_range(2, 5));
        play(1, 4, 2, 1, 2 * 8 + r, -1, prev1);
        stop = 1'b1; start1 = 1'($urandom_range(0, 1));
        tick();
        stop = 1'b0; start1 = 1'b0;
        idle_e = '{addr: 3'd0, code: rom_mem[2], valid: 1'b0, busy: 1'b0, done: 1'b0};
        for (int i = 0; i < 4; i++) begin
            cur_k = 1000 + i;
            check_outputs(1, idle_e);
            tick();
        end
        prev1 = rom_mem[2];

        // reset during entry 3's gap
        play(1, 4, 2, 1, 3 * 8 + 6 + int'($urandom_range(0, 1)), -1, prev1);
        reset_n = 1'b0;
        tick();
        idle_e = '0;
        cur_k = 2000;
        check_outputs(1, idle_e);
        cmp("reset_mid_gap.state", 32'(fsm_state1), 32'(IDLE));
        reset_n = 1'b1;
        tick();
        cur_k = 2001;
        check_outputs(1, idle_e);
        prev1 = 2'd0;

        // Zero gap: 3-cycle entries, done at 21
        play(2, 1, 0, 1, 23, -1, prev2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
